// File: rtl/bit40_div_pkg.sv
// rtl/bit40_div_pkg.sv - shared widths and FSM state type for the 40/8 restoring divider
package bit40_div_pkg;
   localparam int DIVIDEND_W = 40;
   localparam int DIVISOR_W  = 8;
   localparam int NARROW_W   = 32;
   localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring division step
module div_step
   import bit40_div_pkg::*;
(
   input  logic [DIVISOR_W-1:0] rem_in,
   input  logic                 bit_in,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W-1:0] rem_out,
   output logic                 q_bit
);
   logic [DIVISOR_W:0] r_ext;

   // The restored remainder is always below the divisor, so the low bits of the
   // wrapped difference are exact once the 9-bit compare has passed.
   always_comb begin
      r_ext   = {rem_in, bit_in};
      q_bit   = r_ext[DIVISOR_W] | (r_ext[DIVISOR_W-1:0] >= divisor);
      rem_out = q_bit ? (r_ext[DIVISOR_W-1:0] - divisor) : r_ext[DIVISOR_W-1:0];
   end
endmodule

// File: rtl/bit40_div.sv
// rtl/bit40_div.sv - sequential 40/8 unsigned divider, one restoring step per clock
// Optional DIV_SHORTCUT_EN: dividend < divisor finishes directly from IDLE.
module bit40_div
   import bit40_div_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  q_ovf,
   output logic                  div_zero
);
   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0] shreg_q, shreg_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;
   logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
   logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
   logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
   logic                  q_ovf_q, q_ovf_d;
   logic                  div_zero_q, div_zero_d;

   logic [DIVISOR_W-1:0]  step_rem;
   logic                  step_q;
   logic [DIVIDEND_W-1:0] next_shreg;

   div_step u_step (
      .rem_in  (rem_q),
      .bit_in  (shreg_q[DIVIDEND_W-1]),
      .divisor (dvsr_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // Dividend bits leave at the top while quotient bits enter at the bottom.
   assign next_shreg = {shreg_q[DIVIDEND_W-2:0], step_q};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      rem_d       = rem_q;
      dvsr_d      = dvsr_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      q_ovf_d     = q_ovf_q;
      div_zero_d  = div_zero_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               shreg_d = dividend;
               rem_d   = '0;
               dvsr_d  = divisor;
               cnt_d   = '0;
               if (divisor == '0) begin
                  state_d     = DONE;
                  quotient_d  = '1;
                  remainder_d = dividend[DIVISOR_W-1:0];
                  q_ovf_d     = 1'b1;
                  div_zero_d  = 1'b1;
`ifdef DIV_SHORTCUT_EN
               end else if (dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, divisor}) begin
                  state_d     = DONE;
                  quotient_d  = '0;
                  remainder_d = dividend[DIVISOR_W-1:0];
                  q_ovf_d     = 1'b0;
                  div_zero_d  = 1'b0;
`endif
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            shreg_d = next_shreg;
            rem_d   = step_rem;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
               state_d     = DONE;
               quotient_d  = next_shreg;
               remainder_d = step_rem;
               q_ovf_d     = |next_shreg[DIVIDEND_W-1:NARROW_W];
               div_zero_d  = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shreg_q     <= '0;
         rem_q       <= '0;
         dvsr_q      <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         q_ovf_q     <= 1'b0;
         div_zero_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         rem_q       <= rem_d;
         dvsr_q      <= dvsr_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         q_ovf_q     <= q_ovf_d;
         div_zero_q  <= div_zero_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign q_ovf     = q_ovf_q;
   assign div_zero  = div_zero_q;
endmodule

// File: tb/tb_bit40_div.sv
// tb/tb_bit40_div.sv - randomized and directed self-checking bench for bit40_div
module tb_bit40_div;
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [39:0] dividend;
   logic [7:0]  divisor;
   logic        out_valid;
   logic        out_ready;
   logic [39:0] quotient;
   logic [7:0]  remainder;
   logic        q_ovf;
   logic        div_zero;

   int tests = 0;
   int fails = 0;

`ifdef DIV_SHORTCUT_EN
   localparam bit SHORTCUT = 1'b1;
`else
   localparam bit SHORTCUT = 1'b0;
`endif

   bit40_div dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .q_ovf     (q_ovf),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer division; latency counted as cycles from the
   // handshake cycle to the first cycle with out_valid (handshake cycle = 0).
   task automatic model(input logic [39:0] a, input logic [7:0] b,
                        output logic [39:0] q, output logic [7:0] r,
                        output logic ovf, output logic dz, output int lat);
      longint unsigned ua, ub;
      ua = 64'(a);
      ub = 64'(b);
      if (b == 8'd0) begin
         q = {40{1'b1}}; r = a[7:0]; ovf = 1'b1; dz = 1'b1; lat = 1;
      end else begin
         q   = 40'(ua / ub);
         r   = 8'(ua % ub);
         ovf = (ua / ub) >= 64'h1_0000_0000;
         dz  = 1'b0;
         lat = (SHORTCUT && (ua < ub)) ? 1 : 41;
      end
   endtask

   task automatic start_op(input logic [39:0] a, input logic [7:0] b);
      int guard;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Called #1 after the handshake edge.
   task automatic finish_op(input logic [39:0] a, input logic [7:0] b, input int hold);
      logic [39:0] eq;
      logic [7:0]  er;
      logic        eo, ez;
      int          elat, cyc;
      model(a, b, eq, er, eo, ez, elat);
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("latency", 64'(cyc), 64'(elat));
      chk("quotient", 64'(quotient), 64'(eq));
      chk("remainder", 64'(remainder), 64'(er));
      chk("q_ovf", 64'(q_ovf), 64'(eo));
      chk("div_zero", 64'(div_zero), 64'(ez));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_quotient", 64'(quotient), 64'(eq));
         chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("accept_out_valid", 64'(out_valid), 64'd0);
      chk("accept_in_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic run_op(input logic [39:0] a, input logic [7:0] b, input int hold);
      start_op(a, b);
      finish_op(a, b, hold);
   endtask

   initial begin
      logic [63:0] rnd;
      logic [39:0] a;
      logic [7:0]  b;
      logic [39:0] q_saved;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_quotient", 64'(quotient), 64'd0);
      chk("rst_remainder", 64'(remainder), 64'd0);
      chk("rst_q_ovf", 64'(q_ovf), 64'd0);
      chk("rst_div_zero", 64'(div_zero), 64'd0);

      run_op(40'd31, 8'd6, 0);
      chk("t1_quotient_const", 64'(quotient), 64'd5);
      run_op(40'hFE_FFFF_FF01, 8'hFF, 0);
      run_op(40'hFF_FFFF_FFFF, 8'd1, 0);
      run_op(40'd300, 8'd0, 0);
      run_op(40'd5, 8'd6, 0);

      // Result held with out_ready low while a new request waits.
      start_op(40'd2000, 8'd7);
      while (!out_valid) begin
         @(posedge clk);
         #1;
      end
      q_saved = quotient;
      chk("bp_quotient_first", 64'(q_saved), 64'd285);
      @(negedge clk);
      dividend = 40'd77;
      divisor  = 8'd3;
      in_valid = 1'b1;
      for (int h = 0; h < 10; h++) begin
         @(posedge clk);
         #1;
         chk("bp_stable_q", 64'(quotient), 64'(q_saved));
         chk("bp_stable_r", 64'(remainder), 64'd5);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_not_taken_yet", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_taken", 64'(in_ready), 64'd0);
      finish_op(40'd77, 8'd3, 0);

      // Reset in the middle of a running division.
      start_op(40'd300, 8'd10);
      repeat (19) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_quotient", 64'(quotient), 64'd0);
      run_op(40'd300, 8'd10, 0);
      chk("after_rst_q_const", 64'(quotient), 64'd30);

      for (int i = 0; i < 16; i++) begin
         rnd = {$urandom, $urandom};
         a   = rnd[39:0];
         if ($urandom_range(0, 3) == 0) a = 40'($urandom_range(0, 300));
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) b = 8'd0;
         run_op(a, b, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
